// File: rtl/pal_cfg_loader_if.sv
// Word-in / serial-out bundle for the PAL configuration loader.
// Master side issues commands and words; slave side returns chain strobes and status.
interface pal_cfg_loader_if #(
   parameter int WORD_W = 8
);
   logic              start;
   logic              abort;
   logic [WORD_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              cfg_data;
   logic              cfg_shift;
   logic              pal_en;
   logic              busy;
   logic              done;

   modport master (
      output start, abort, in_data, in_valid,
      input  in_ready, cfg_data, cfg_shift, pal_en, busy, done
   );

   modport slave (
      input  start, abort, in_data, in_valid,
      output in_ready, cfg_data, cfg_shift, pal_en, busy, done
   );
endinterface

// File: rtl/pal_cfg_loader.sv
// Serialises WORD_W-bit configuration words LSB first into a CFG_BITS-long PAL chain,
// one word accept plus one shift per bit; PAL_EN goes live once the whole chain is loaded.
module pal_cfg_loader #(
   parameter int CFG_BITS = 192,
   parameter int WORD_W   = 8
) (
   input logic             clk,
   input logic             res,
   pal_cfg_loader_if.slave bus
);

   localparam int BW = $clog2(CFG_BITS + 1);
   localparam int CW = $clog2(WORD_W + 1);

   if (CFG_BITS < 1 || WORD_W < 1) begin : g_bad_params
      $error("pal_cfg_loader: CFG_BITS and WORD_W must both be at least 1");
   end

   typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, LOADED} state_t;

   state_t            state, state_nxt;
   logic [BW-1:0]     bits_sent;
   logic [CW-1:0]     word_left;
   logic [WORD_W-1:0] sreg;
   logic [BW-1:0]     remain;
   logic [CW-1:0]     word_len;
   logic              last_bit;
   logic              last_of_cfg;

   // Final word may be partial: only the bits still owed to the chain are shifted.
   assign remain      = BW'(CFG_BITS) - bits_sent;
   assign last_bit    = (word_left == CW'(1));
   assign last_of_cfg = ((32'(bits_sent) + 32'd1) == 32'(CFG_BITS));

   always_comb begin
      word_len = CW'(WORD_W);
      if (32'(remain) < 32'(WORD_W)) begin
         word_len = CW'(remain);
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.cfg_data  = 1'b0;
      bus.cfg_shift = 1'b0;
      bus.pal_en    = 1'b0;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_nxt = WAIT_WORD;
         end
         WAIT_WORD: begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b1;
            if (bus.in_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            bus.busy      = 1'b1;
            bus.cfg_shift = 1'b1;
            bus.cfg_data  = sreg[0];
            if (last_bit) state_nxt = last_of_cfg ? LOADED : WAIT_WORD;
         end
         LOADED: begin
            bus.pal_en = 1'b1;
            bus.done   = 1'b1;
            if (bus.start) state_nxt = WAIT_WORD;
         end
         default: state_nxt = IDLE;
      endcase
      if (bus.abort) state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         bits_sent <= '0;
         word_left <= '0;
         sreg      <= '0;
      end else if (bus.abort) begin
         bits_sent <= '0;
         word_left <= '0;
         sreg      <= '0;
      end else begin
         case (state)
            IDLE, LOADED: begin
               if (bus.start) bits_sent <= '0;
            end
            WAIT_WORD: begin
               if (bus.in_valid) begin
                  sreg      <= bus.in_data;
                  word_left <= word_len;
               end
            end
            SHIFT: begin
               sreg      <= sreg >> 1;
               bits_sent <= bits_sent + BW'(1);
               word_left <= word_left - CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Directed bench: full 192-bit loads, partial final word, gapped input, abort and async reset.
module tb_pal_cfg_loader;

   logic clk = 1'b0;
   logic res = 1'b1;
   always #5 clk = ~clk;

   pal_cfg_loader_if #(.WORD_W(8)) a ();
   pal_cfg_loader_if #(.WORD_W(8)) b ();

   pal_cfg_loader #(.CFG_BITS(192), .WORD_W(8)) dut_a (.clk(clk), .res(res), .bus(a.slave));
   pal_cfg_loader #(.CFG_BITS(20),  .WORD_W(8)) dut_b (.clk(clk), .res(res), .bus(b.slave));

   int n_checks = 0;
   int n_pass   = 0;

   bit          sa[$];
   bit          sb[$];
   logic [7:0]  w[24];
   logic [7:0]  wb[3];

   always @(negedge clk) begin
      if (a.cfg_shift) sa.push_back(a.cfg_data);
      if (b.cfg_shift) sb.push_back(b.cfg_data);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] outs_a();
      return {a.in_ready, a.cfg_data, a.cfg_shift, a.pal_en, a.busy, a.done};
   endfunction

   function automatic logic [5:0] outs_b();
      return {b.in_ready, b.cfg_data, b.cfg_shift, b.pal_en, b.busy, b.done};
   endfunction

   task automatic start_a;
      a.start = 1'b1;
      tick;
      a.start = 1'b0;
   endtask

   // Word d held valid back-to-back: expect 24*9 cycles and d's bits repeated LSB first.
   task automatic run_held_a(input logic [7:0] d, input string tag);
      int cyc;
      int errs;
      sa.delete();
      a.in_valid = 1'b1;
      a.in_data  = d;
      cyc = 0;
      while (a.done !== 1'b1 && cyc < 400) begin
         tick;
         cyc++;
      end
      a.in_valid = 1'b0;
      check({tag, "_cycles"}, cyc, 216);
      check({tag, "_pal_en"}, a.pal_en, 1);
      check({tag, "_count"}, sa.size(), 192);
      errs = 0;
      for (int i = 0; i < sa.size(); i++) begin
         if (sa[i] !== d[i % 8]) errs++;
      end
      check({tag, "_stream"}, errs, 0);
   endtask

   initial begin
      int n;
      int errs;
      int gerr;

      a.start = 0; a.abort = 0; a.in_data = 0; a.in_valid = 0;
      b.start = 0; b.abort = 0; b.in_data = 0; b.in_valid = 0;
      for (int k = 0; k < 24; k++) w[k] = 8'(k * 37 + 11);
      wb[0] = 8'hFF; wb[1] = 8'h00; wb[2] = 8'h3C;

      #12;
      check("reset_outs_a", outs_a(), 0);
      check("reset_outs_b", outs_b(), 0);
      @(negedge clk) res = 1'b0;
      tick;
      check("idle_outs", outs_a(), 0);

      // ABORT wins over START in the same cycle
      a.start = 1'b1; a.abort = 1'b1;
      tick;
      a.start = 1'b0; a.abort = 1'b0;
      check("abort_over_start", outs_a(), 0);

      // Default chain, 0xA5 held
      start_a;
      check("wait_ready", a.in_ready, 1);
      check("wait_busy_noshift", {a.busy, a.cfg_shift, a.cfg_data}, 3'b100);
      run_held_a(8'hA5, "a5");
      check("loaded_not_busy", {a.busy, a.in_ready}, 2'b00);

      // 20-bit chain: 8 + 8 + 4 bits, upper half of 0x3C discarded
      b.start = 1'b1;
      tick;
      b.start = 1'b0;
      sb.delete();
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (b.in_ready !== 1'b1 && n < 20) begin tick; n++; end
         b.in_valid = 1'b1;
         b.in_data  = wb[k];
         tick;
         b.in_valid = 1'b0;
      end
      n = 0;
      while (b.done !== 1'b1 && n < 20) begin tick; n++; end
      check("short_done", {b.done, b.pal_en}, 2'b11);
      check("short_count", sb.size(), 20);
      errs = 0;
      for (int i = 0; i < 16; i++) begin
         if (sb[i] !== wb[i / 8][i % 8]) errs++;
      end
      check("short_first16", errs, 0);
      check("short_last4", {sb[16], sb[17], sb[18], sb[19]}, 4'b0011);

      // START from LOADED drops PAL_EN, then gapped words
      start_a;
      check("restart_pal_en", {a.pal_en, a.done, a.busy}, 3'b001);
      sa.delete();
      gerr = 0;
      for (int k = 0; k < 24; k++) begin
         n = 0;
         while (a.in_ready !== 1'b1 && n < 20) begin tick; n++; end
         if (n >= 20) gerr++;
         for (int g = 0; g < 5; g++) begin
            if (a.in_ready !== 1'b1 || a.cfg_shift !== 1'b0) gerr++;
            tick;
         end
         a.in_valid = 1'b1;
         a.in_data  = w[k];
         tick;
         a.in_valid = 1'b0;
      end
      n = 0;
      while (a.done !== 1'b1 && n < 20) begin tick; n++; end
      check("gap_hold", gerr, 0);
      check("gap_done", a.done, 1);
      check("gap_count", sa.size(), 192);
      errs = 0;
      for (int i = 0; i < sa.size(); i++) begin
         if (sa[i] !== w[i / 8][i % 8]) errs++;
      end
      check("gap_stream", errs, 0);

      // ABORT on the 3rd bit of word 10
      start_a;
      sa.delete();
      a.in_valid = 1'b1;
      a.in_data  = 8'h5A;
      repeat (84) tick;
      check("abort_in_shift", {a.cfg_shift, a.busy}, 2'b11);
      a.abort = 1'b1;
      a.start = 1'b1;
      tick;
      a.abort = 1'b0;
      a.start = 1'b0;
      a.in_valid = 1'b0;
      check("abort_idle", outs_a(), 0);
      check("abort_bits", sa.size(), 75);
      tick;
      check("abort_stays_idle", outs_a(), 0);
      start_a;
      run_held_a(8'h3C, "reload");

      // Async reset between edges mid-shift
      start_a;
      a.in_valid = 1'b1;
      a.in_data  = 8'hC3;
      repeat (20) tick;
      check("pre_reset_shift", a.cfg_shift, 1);
      a.in_valid = 1'b0;
      #1 res = 1'b1;
      #1 check("async_reset", outs_a(), 0);
      #1 res = 1'b0;
      tick;
      check("post_reset_idle", outs_a(), 0);
      start_a;
      run_held_a(8'hC3, "after_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pal_cfg_loader.md
PAL_CFG_LOADER -- requirements
Module: pal_cfg_loader

Interface
REQ-001 Parameter CFG_BITS, default 192, SHALL set the total configuration chain length in bits; the default is the AND plane (2*8*8) plus the OR plane (8*8).
REQ-002 Parameter WORD_W, default 8, SHALL set the parallel input word width in bits.
REQ-003 CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 RES  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 START  input  1  SHALL request a new configuration load when high for one cycle.
REQ-006 ABORT  input  1  SHALL cancel an in-progress load.
REQ-007 IN_DATA  input  WORD_W  SHALL carry the configuration word.
REQ-008 IN_VALID  input  1  SHALL mark IN_DATA as valid.
REQ-009 IN_READY  output  1  SHALL indicate that the loader accepts a word this cycle.
REQ-010 CFG_DATA  output  1  SHALL carry the serial configuration bit to the PAL chain.
REQ-011 CFG_SHIFT  output  1  SHALL be a strobe meaning "shift CFG_DATA into the chain this cycle".
REQ-012 PAL_EN  output  1  SHALL drive the PAL apply-enable; high means the loaded configuration is live.
REQ-013 BUSY  output  1  SHALL be high while a load is in progress.
REQ-014 DONE  output  1  SHALL be high after a successful load, until the next START or ABORT.

Function
REQ-015 The FSM SHALL have four states: IDLE, WAIT_WORD, SHIFT and LOADED.
REQ-016 IDLE/LOADED + START=1 -> WAIT_WORD on the next edge; bit-total counter cleared, PAL_EN=0, DONE=0.
REQ-017 START SHALL be ignored in WAIT_WORD and SHIFT.
REQ-018 IN_READY SHALL be 1 only in WAIT_WORD; it SHALL be combinational from state only, never from IN_VALID.
REQ-019 A word SHALL be accepted on an edge where IN_VALID=1 and IN_READY=1; the word is latched into the shift register and the FSM enters SHIFT.
REQ-020 In SHIFT: CFG_SHIFT=1 every cycle; CFG_DATA = current LSB of the shift register; the register shifts right by one per cycle (LSB first).
REQ-021 Bits per word SHALL be min(WORD_W, CFG_BITS - bits_sent); excess upper bits of the final word are discarded and never shifted.
REQ-022 After the last bit of a word:
  - bits_sent < CFG_BITS -> WAIT_WORD.
  - bits_sent == CFG_BITS -> LOADED.
REQ-023 LOADED SHALL drive PAL_EN=1 and DONE=1, held until START or ABORT.
REQ-024 Outside SHIFT: CFG_SHIFT=0 and CFG_DATA=0.
REQ-025 BUSY SHALL be 1 exactly in WAIT_WORD and SHIFT.
REQ-026 Counter widths:
  - bits_sent: clog2(CFG_BITS+1) bits.
  - per-word bit counter: clog2(WORD_W+1) bits.
  - Neither counter SHALL wrap.
REQ-027 ABORT=1 in any state SHALL move the FSM to IDLE on the next edge with PAL_EN=0, DONE=0, counters cleared; ABORT SHALL take priority over START and IN_VALID in the same cycle.
REQ-028 Minimum load time SHALL be ceil(CFG_BITS/WORD_W) word accepts plus CFG_BITS shift cycles; each word costs WORD_W+1 cycles when IN_VALID is held high.
REQ-029 CFG_BITS>=1 and WORD_W>=1 SHALL be the only legal parameter values.

Reset
REQ-030 RES=1 SHALL immediately force:
  - state IDLE, counters and shift register zero;
  - IN_READY=0, CFG_DATA=0, CFG_SHIFT=0, PAL_EN=0, BUSY=0, DONE=0;
  independent of CLK.
REQ-031 RES asserted mid-load SHALL discard the partial load; the next START SHALL restart from bit 0.

Verification
REQ-032 Default parameters, START, 24 words 0xA5 with IN_VALID held -> 192 CFG_SHIFT pulses; bit stream repeats 1,0,1,0,0,1,0,1; DONE=1 and PAL_EN=1 exactly 24*9 cycles after the START edge.
REQ-033 CFG_BITS=20, WORD_W=8, words 0xFF,0x00,0x3C -> 8+8+4 pulses; last four bits 0,0,1,1; LOADED after 20 bits.
REQ-034 IN_VALID withheld 5 cycles between words -> FSM waits in WAIT_WORD with IN_READY=1 and CFG_SHIFT=0; the serial stream is identical to back-to-back input.
REQ-035 ABORT at the 3rd bit of word 10 -> IDLE next edge, PAL_EN=0, BUSY=0; a following full load completes correctly.
REQ-036 RES pulse asserted between clock edges during SHIFT -> all outputs 0 before the next edge; START in LOADED -> PAL_EN drops the next cycle and a new load begins.
